// File: rtl/wram2asciiram_bridge.sv
// wram2asciiram_bridge: queues CPU word stores aimed at the VGA text window and
// replays them as per-character ASCII RAM writes, remapping rows by a scroll register.
module wram2asciiram_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h00EF_FF00,
    parameter int unsigned ROW_BITS   = 5,
    parameter int unsigned COL_BITS   = 7,
    parameter logic [31:0] CTRL_ADDR  = 32'h00EF_FEFC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_we,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    input  logic [3:0]                   cpu_be,
    output logic                         cpu_stall,
    output logic                         ram_we,
    input  logic                         ram_gnt,
    output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
    output logic [7:0]                   ram_data,
    output logic [ROW_BITS-1:0]          scroll_row,
    output logic                         busy
);
    localparam int unsigned AW     = ROW_BITS + COL_BITS;
    localparam int unsigned WW     = AW - 2;
    localparam int unsigned PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W  = PW + 1;
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + (33'd1 << AW);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [31:0]       word_addr;
    logic [1:0]        unused_addr_bits;
    logic              in_win;
    logic              is_ctrl;
    logic [WW-1:0]     win_word;

    logic [WW-1:0]     fifo_word_q [FIFO_DEPTH];
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [3:0]        fifo_be_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              ctrl_acc;

    logic [0:0]        state_q, state_d;
    logic [WW-1:0]     hold_word_q, hold_word_d;
    logic [31:0]       hold_data_q, hold_data_d;
    logic [3:0]        rem_q, rem_d;
    logic              ram_we_q, ram_we_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic [ROW_BITS-1:0] scroll_q, scroll_d;

    logic              issue;
    logic [WW-1:0]     src_word;
    logic [31:0]       src_data;
    logic [3:0]        src_mask;
    logic [1:0]        lane;
    logic [AW-1:0]     char_off;
    logic [ROW_BITS-1:0] phys_row;

    // Lowest enabled byte lane of a mask; ascending lane order means ascending address.
    function automatic logic [1:0] first_lane(input logic [3:0] m);
        logic [1:0] l;
        if (m[0])      l = 2'd0;
        else if (m[1]) l = 2'd1;
        else if (m[2]) l = 2'd2;
        else           l = 2'd3;
        return l;
    endfunction

    // Big-endian lane select: lane 0 is the most significant byte.
    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        return b;
    endfunction

    assign word_addr        = {cpu_addr[31:2], 2'b00};
    assign unused_addr_bits = cpu_addr[1:0];
    assign in_win   = ({1'b0, word_addr} >= WIN_LO) && ({1'b0, word_addr} < WIN_HI);
    assign is_ctrl  = (word_addr == CTRL_ADDR);
    assign win_word = WW'((word_addr - BASE_ADDR) >> 2);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign busy      = !fifo_empty || (state_q != S_IDLE);
    assign cpu_stall = cpu_we && ((in_win && fifo_full) || (is_ctrl && busy));
    assign push      = cpu_we && in_win && !fifo_full && (cpu_be != 4'd0);
    assign ctrl_acc  = cpu_we && is_ctrl && !busy;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign scroll_d = ctrl_acc ? cpu_wdata[ROW_BITS-1:0] : scroll_q;

    // FIFO storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word_q[wr_ptr_q[PW-1:0]] <= win_word;
            fifo_data_q[wr_ptr_q[PW-1:0]] <= cpu_wdata;
            fifo_be_q[wr_ptr_q[PW-1:0]]   <= cpu_be;
        end
    end

    // Serializer next state: a grant either advances the lane, chains into the next entry, or idles.
    always_comb begin
        state_d     = state_q;
        hold_word_d = hold_word_q;
        hold_data_d = hold_data_q;
        rem_d       = rem_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        pop         = 1'b0;
        issue       = 1'b0;
        src_word    = hold_word_q;
        src_data    = hold_data_q;
        src_mask    = rem_q;
        lane        = 2'd0;
        char_off    = '0;
        phys_row    = '0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    issue    = 1'b1;
                    src_word = fifo_word_q[rd_ptr_q[PW-1:0]];
                    src_data = fifo_data_q[rd_ptr_q[PW-1:0]];
                    src_mask = fifo_be_q[rd_ptr_q[PW-1:0]];
                end
            end
            S_EMIT: begin
                if (ram_gnt) begin
                    if (rem_q != 4'd0) begin
                        issue = 1'b1;
                    end else if (!fifo_empty) begin
                        pop      = 1'b1;
                        issue    = 1'b1;
                        src_word = fifo_word_q[rd_ptr_q[PW-1:0]];
                        src_data = fifo_data_q[rd_ptr_q[PW-1:0]];
                        src_mask = fifo_be_q[rd_ptr_q[PW-1:0]];
                    end else begin
                        ram_we_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            lane        = first_lane(src_mask);
            char_off    = {src_word, lane};
            phys_row    = char_off[AW-1:COL_BITS] + scroll_q;
            ram_we_d    = 1'b1;
            ram_addr_d  = {phys_row, char_off[COL_BITS-1:0]};
            ram_data_d  = lane_byte(src_data, lane);
            hold_word_d = src_word;
            hold_data_d = src_data;
            rem_d       = src_mask & ~(4'd1 << lane);
            state_d     = S_EMIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            hold_word_q <= '0;
            hold_data_q <= '0;
            rem_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            scroll_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            hold_word_q <= hold_word_d;
            hold_data_q <= hold_data_d;
            rem_q       <= rem_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            scroll_q    <= scroll_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign scroll_row = scroll_q;

endmodule

// File: tb/tb_wram2asciiram_bridge.sv
// Bench for wram2asciiram_bridge: directed and random stores checked against a
// character-stream model of the text window.
module tb_wram2asciiram_bridge;
    localparam logic [31:0] BASE = 32'h00EF_FF00;
    localparam logic [31:0] CTRL = 32'h00EF_FEFC;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } chr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_stall;
    logic        ram_we;
    logic        ram_gnt;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic [4:0]  scroll_row;
    logic        busy;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   model_scroll = 0;
    chr_t exp_q[$];
    chr_t obs_q[$];
    int   obs_cyc[$];

    wram2asciiram_bridge dut (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_stall(cpu_stall),
        .ram_we(ram_we), .ram_gnt(ram_gnt), .ram_addr(ram_addr),
        .ram_data(ram_data), .scroll_row(scroll_row), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every completed handshake is one character written to the text RAM.
    always @(negedge clk) begin
        if (!rst && ram_we && ram_gnt) begin
            obs_q.push_back({ram_addr, ram_data});
            obs_cyc.push_back(cyc);
        end
    end

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] be);
        int off, row, col, phys;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                off  = int'((a & 32'hFFFF_FFFC) - BASE) + i;
                row  = off / 128;
                col  = off % 128;
                phys = (row + model_scroll) % 32;
                b    = 8'(d >> (24 - 8 * i));
                exp_q.push_back({12'(phys * 128 + col), b});
            end
        end
    endfunction

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // Present one store, hold it while stalled, and record the model effect on acceptance.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int acc, output bit ok, output int stalls);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        cpu_addr = a; cpu_wdata = d; cpu_be = be; cpu_we = 1'b1;
        ok = 1'b0; acc = -1; stalls = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                ok  = 1'b1;
                acc = cyc;
                if (w >= BASE && w < BASE + 32'h1000) begin
                    if (be != 4'd0) model_store(a, d, be);
                end else if (w == CTRL) begin
                    model_scroll = int'(d[4:0]);
                end
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        cpu_we = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (!busy && !ram_we) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0; ram_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (ram_we !== 1'b0) $display("FAIL reset ram_we: got %b want 0", ram_we); else n_pass++;
        n_total++; if (ram_addr !== 12'd0) $display("FAIL reset ram_addr: got %h want 000", ram_addr); else n_pass++;
        n_total++; if (ram_data !== 8'd0) $display("FAIL reset ram_data: got %h want 00", ram_data); else n_pass++;
        n_total++; if (scroll_row !== 5'd0) $display("FAIL reset scroll_row: got %0d want 0", scroll_row); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // One full word at character (0,0): four writes starting two cycles after acceptance.
    task automatic test_basic(input string tag);
        int acc, stalls; bit ok, idle;
        logic [7:0] want_data [4];
        want_data[0] = 8'h41; want_data[1] = 8'h42; want_data[2] = 8'h43; want_data[3] = 8'h44;
        ram_gnt = 1'b1;
        clear_queues();
        do_store(32'h00EF_FF00, 32'h4142_4344, 4'hF, acc, ok, stalls);
        wait_idle(idle);
        n_total++; if (!(ok && idle)) $display("FAIL %s timeout: accepted=%b idle=%b want 1/1", tag, ok, idle); else n_pass++;
        n_total++; if (obs_q.size() != 4) $display("FAIL %s count: got %0d want 4", tag, obs_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= obs_q.size())
                $display("FAIL %s char %0d missing", tag, i);
            else if (obs_q[i] !== {12'(i), want_data[i]} || obs_cyc[i] != acc + 2 + i)
                $display("FAIL %s char %0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                         tag, i, obs_q[i].addr, obs_q[i].data, obs_cyc[i], 12'(i), want_data[i], acc + 2 + i);
            else n_pass++;
        end
        n_total++; if (ram_we !== 1'b0 || busy !== 1'b0) $display("FAIL %s end state: got we=%b busy=%b want 0/0", tag, ram_we, busy); else n_pass++;
        clear_queues();
    endtask

    task automatic test_byte_enables();
        int acc, acc0, stalls; bit ok, idle;
        ram_gnt = 1'b1;
        clear_queues();
        do_store(32'h00EF_FF84, 32'h3132_3334, 4'b0101, acc, ok, stalls);
        wait_idle(idle);
        n_total++; if (obs_q.size() != 2) $display("FAIL be0101 count: got %0d want 2", obs_q.size()); else n_pass++;
        if (obs_q.size() == 2) begin
            n_total++; if (obs_q[0] !== {5'd1, 7'd4, 8'h31}) $display("FAIL be0101 char0: got %h want %h", obs_q[0], {5'd1, 7'd4, 8'h31}); else n_pass++;
            n_total++; if (obs_q[1] !== {5'd1, 7'd6, 8'h33}) $display("FAIL be0101 char1: got %h want %h", obs_q[1], {5'd1, 7'd6, 8'h33}); else n_pass++;
            n_total++; if (obs_cyc[1] != obs_cyc[0] + 1) $display("FAIL be0101 bubble: got gap %0d want 1", obs_cyc[1] - obs_cyc[0]); else n_pass++;
        end
        clear_queues();
        do_store(32'h00EF_FF10, 32'hDEAD_BEEF, 4'b0000, acc0, ok, stalls);
        repeat (4) @(posedge clk);
        #1;
        n_total++; if (!ok || stalls != 0) $display("FAIL be0 stall: got accepted=%b stalls=%0d want 1/0", ok, stalls); else n_pass++;
        n_total++; if (obs_q.size() != 0 || busy !== 1'b0) $display("FAIL be0 writes: got %0d chars busy=%b want 0/0", obs_q.size(), busy); else n_pass++;
        clear_queues();
    endtask

    // The first entry moves straight into the serializer, so the sixth store is the one that finds the FIFO full.
    task automatic test_fifo_full();
        int acc, stalls, nst; bit ok, idle, held, acc6;
        logic [31:0] a, d; logic [3:0] be;
        logic [11:0] cap_addr; logic [7:0] cap_data;
        ram_gnt = 1'b0;
        clear_queues();
        nst = 0;
        for (int s = 0; s < 5; s++) begin
            a = BASE + 32'(4 * $urandom_range(0, 1023));
            d = $urandom;
            be = 4'($urandom_range(1, 15));
            do_store(a, d, be, acc, ok, stalls);
            nst += stalls;
        end
        n_total++; if (nst != 0) $display("FAIL fifo fill stalls: got %0d want 0", nst); else n_pass++;
        @(negedge clk);
        cap_addr = ram_addr; cap_data = ram_data;
        n_total++; if (ram_we !== 1'b1) $display("FAIL fifo hold ram_we: got %b want 1", ram_we); else n_pass++;
        @(posedge clk); #1;
        a = BASE + 32'(4 * $urandom_range(0, 1023));
        d = $urandom;
        cpu_addr = a; cpu_wdata = d; cpu_be = 4'hF; cpu_we = 1'b1;
        held = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cpu_stall !== 1'b1 || ram_we !== 1'b1 || ram_addr !== cap_addr || ram_data !== cap_data) held = 1'b0;
            @(posedge clk); #1;
        end
        n_total++; if (!held) $display("FAIL fifo full hold: got stall=%b addr=%h data=%h want 1/%h/%h", cpu_stall, ram_addr, ram_data, cap_addr, cap_data); else n_pass++;
        ram_gnt = 1'b1;
        acc6 = 1'b0;
        for (int k = 0; k < 100 && !acc6; k++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                acc6 = 1'b1;
                model_store(a, d, 4'hF);
            end
            @(posedge clk); #1;
        end
        cpu_we = 1'b0;
        wait_idle(idle);
        n_total++; if (!(acc6 && idle)) $display("FAIL fifo drain timeout: got accepted=%b idle=%b want 1/1", acc6, idle); else n_pass++;
        n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL fifo drain count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL fifo drain char %0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        clear_queues();
    endtask

    task automatic test_scroll();
        int acc, stalls, ctrl_stalls; bit ok, idle;
        logic [4:0] sv;
        ram_gnt = 1'b1;
        clear_queues();
        do_store(BASE + 32'(4 * $urandom_range(0, 1023)), $urandom, 4'hF, acc, ok, stalls);
        do_store(BASE + 32'(4 * $urandom_range(0, 1023)), $urandom, 4'hF, acc, ok, stalls);
        do_store(CTRL, 32'h0000_001F, 4'hF, acc, ok, ctrl_stalls);
        n_total++; if (!ok || ctrl_stalls == 0) $display("FAIL ctrl busy stall: got accepted=%b stalls=%0d want 1/>0", ok, ctrl_stalls); else n_pass++;
        n_total++; if (scroll_row !== 5'd31) $display("FAIL ctrl scroll: got %0d want 31", scroll_row); else n_pass++;
        do_store(32'h00F0_0000, 32'h5800_0000, 4'b0001, acc, ok, stalls);
        wait_idle(idle);
        n_total++;
        if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== {5'd1, 7'd0, 8'h58})
            $display("FAIL scroll wrap: got %h want %h", (obs_q.size() == 0) ? 20'h0 : obs_q[obs_q.size() - 1], {5'd1, 7'd0, 8'h58});
        else n_pass++;
        n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL scroll count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL scroll char %0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        clear_queues();
        sv = 5'($urandom_range(0, 31));
        do_store(CTRL, {27'($urandom), sv}, 4'hF, acc, ok, stalls);
        for (int s = 0; s < 4; s++)
            do_store(BASE + 32'(4 * $urandom_range(0, 1023)), $urandom, 4'($urandom_range(1, 15)), acc, ok, stalls);
        wait_idle(idle);
        n_total++; if (scroll_row !== 5'(model_scroll)) $display("FAIL rand scroll reg: got %0d want %0d", scroll_row, model_scroll); else n_pass++;
        n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand scroll count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rand scroll char %0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        clear_queues();
    endtask

    task automatic test_ignored();
        int acc, s1, s2; bit ok1, ok2, quiet;
        ram_gnt = 1'b1;
        clear_queues();
        do_store(32'h00F0_0F00, 32'h4142_4344, 4'hF, acc, ok1, s1);
        do_store(32'h00EF_FEF8, 32'h0000_0003, 4'hF, acc, ok2, s2);
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ram_we !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        @(posedge clk); #1;
        n_total++; if (!ok1 || !ok2 || s1 != 0 || s2 != 0) $display("FAIL ignored stall: got stalls=%0d/%0d want 0/0", s1, s2); else n_pass++;
        n_total++; if (!quiet || obs_q.size() != 0) $display("FAIL ignored writes: got %0d chars quiet=%b want 0/1", obs_q.size(), quiet); else n_pass++;
        n_total++; if (scroll_row !== 5'(model_scroll)) $display("FAIL ignored scroll: got %0d want %0d", scroll_row, model_scroll); else n_pass++;
        clear_queues();
    endtask

    task automatic test_reset_mid();
        int acc, stalls; bit ok, idle;
        ram_gnt = 1'b1;
        clear_queues();
        do_store(CTRL, 32'h0000_0005, 4'hF, acc, ok, stalls);
        for (int s = 0; s < 3; s++)
            do_store(BASE + 32'(4 * $urandom_range(0, 1023)), $urandom, 4'hF, acc, ok, stalls);
        @(negedge clk);
        n_total++; if (ram_we !== 1'b1 || scroll_row !== 5'd5) $display("FAIL mid-drain pre: got we=%b scroll=%0d want 1/5", ram_we, scroll_row); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_total++; if (ram_we !== 1'b0 || busy !== 1'b0 || scroll_row !== 5'd0)
            $display("FAIL mid-drain reset: got we=%b busy=%b scroll=%0d want 0/0/0", ram_we, busy, scroll_row); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0 || ram_addr !== 12'd0 || ram_data !== 8'd0)
            $display("FAIL mid-drain held: got busy=%b addr=%h data=%h want 0/000/00", busy, ram_addr, ram_data); else n_pass++;
        rst = 1'b0;
        model_scroll = 0;
        clear_queues();
        @(posedge clk); #1;
        wait_idle(idle);
        test_basic("post-reset");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_byte_enables();
        test_fifo_full();
        test_scroll();
        test_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
